instruction_encode_loader: RTL and testbench
============================================

INSTRUCTION_ENCODE_LOADER -- requirements
Module: instruction_encode_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address of the first instruction word written.
REQ-002 Parameter DEPTH, default 256: instruction-memory window size in words; the write address wraps within this window.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  pulse that opens a load session.
REQ-006 in_valid / in_ready  in / out  1 / 1  field-tuple handshake.
REQ-007 in_last  in  1  marks the final tuple of the session.
REQ-008 in_type  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=J, 5..7 illegal.
REQ-009 in_rs, in_rt, in_rd, in_shamt  in  5 each  register/shift fields.
REQ-010 in_funct  in  6  R-type function field.
REQ-011 in_imm  in  16  immediate field.
REQ-012 in_target  in  26  jump target field.
REQ-013 imem_we, imem_addr, imem_wdata  out  1, 32, 32  instruction-memory write port.
REQ-014 imem_ready  in  1  the memory accepts the write this cycle.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when the session completes.
REQ-017 count  out  16  words written this session; saturates at 16'hFFFF.
REQ-018 err  out  1  sticky illegal-tuple flag; present only with ENCODE_CHECK_EN.

Function
REQ-019 Encoding:
- R-type: {6'h00, rs, rt, rd, shamt, funct}.
- LW: {6'h23, rs, rt, imm}.
- SW: {6'h2B, rs, rt, imm}.
- BEQ: {6'h04, rs, rt, imm}.
- J: {6'h02, target}.
REQ-020 The encoded word is pushed into a 2-entry registered FIFO on the in_valid & in_ready cycle.
REQ-021 The FSM has four states: IDLE, LOAD, DRAIN, DONE.
REQ-022 IDLE behaviour:
- in_ready=0.
- start moves the FSM to LOAD, sets imem_addr=BASE_ADDR and count=0, and clears err.
REQ-023 LOAD behaviour: in_ready = FIFO not full; a pop in the same cycle does not create space (no pass-through when full).
REQ-024 Accepting a tuple with in_last=1 moves the FSM to DRAIN; in_ready=0 from the next cycle.
REQ-025 DRAIN: when the FIFO is empty and no write is pending, the FSM moves to DONE.
REQ-026 DONE: done=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-027 In LOAD and DRAIN, imem_we = FIFO not empty and imem_wdata = FIFO head.
REQ-028 A write completes on a cycle with imem_we & imem_ready; that cycle:
- pops the FIFO;
- advances imem_addr by 4;
- increments count.
REQ-029 Address wrap: a completed write at BASE_ADDR+4*(DEPTH-1) sets the next imem_addr to BASE_ADDR.
REQ-030 While imem_ready=0, imem_we, imem_addr and imem_wdata hold stable.
REQ-031 Latency: an accepted tuple reaches imem_wdata with imem_we=1 no earlier than the next cycle.
REQ-032 start is ignored outside IDLE.
REQ-033 A push and a pop in the same cycle are both honoured; occupancy is unchanged.

Reset
REQ-034 reset forces, on the next edge, including mid-session:
- state=IDLE and FIFO empty;
- imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0;
- in_ready=0, busy=0, done=0, count=0, err=0.
REQ-035 Writes pending at reset are discarded and never issued.

Configuration
REQ-036 The macro ENCODE_CHECK_EN selects handling of illegal types.
REQ-037 With ENCODE_CHECK_EN defined, an illegal in_type (5..7):
- is accepted by the handshake but not pushed;
- is not counted;
- sets err until the next start or reset;
- still triggers DRAIN if in_last=1.
REQ-038 Without ENCODE_CHECK_EN, the err port is absent and an illegal type encodes and writes 32'h0000_0000.

Verification
REQ-039 start; LW rs=2 rt=3 imm=16'h0010, last; imem_ready=1 -> one write of 32'h8C43_0010 at 0x0; done pulse; count=1.
REQ-040 R rs=1 rt=2 rd=3 funct=6'h20, then J target=26'h000_0040 last -> 32'h0022_1820 at 0x0, then 32'h0800_0040 at 0x4.
REQ-041 imem_ready=0 for 5 cycles with 3 tuples offered -> 2 accepted, in_ready=0, outputs stable; releasing imem_ready completes in order.
REQ-042 DEPTH=4, 6 tuples -> addresses 0x0, 0x4, 0x8, 0xC, 0x0, 0x4; count=6.
REQ-043 reset after 1 of 3 writes -> no further imem_we; all outputs at reset values; next start writes at BASE_ADDR.
REQ-044 With ENCODE_CHECK_EN, type 6 with last -> no write, err=1, done pulses, count=0.

Source files
------------

// File: rtl/instruction_encode_loader_if.sv
// instruction_encode_loader_if: tuple handshake, instruction-memory write port and status.
interface instruction_encode_loader_if;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [2:0]  in_type;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [5:0]  in_funct;
    logic [15:0] in_imm;
    logic [25:0] in_target;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        imem_ready;
    logic        busy;
    logic        done;
    logic [15:0] count;
    modport master (
        output start, in_valid, in_last, in_type, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata, busy, done, count
    );
    modport slave (
        input  start, in_valid, in_last, in_type, in_rs, in_rt, in_rd, in_shamt,
               in_funct, in_imm, in_target, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata, busy, done, count
    );
endinterface

// File: rtl/instruction_encode_loader.sv
// instruction_encode_loader: encodes field tuples into instruction words and streams them to memory.
// Macro ENCODE_CHECK_EN drops illegal types (5..7) and adds the sticky err output.
module instruction_encode_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 256
) (
    input  logic clk,
    input  logic reset,
`ifdef ENCODE_CHECK_EN
    output logic err,
`endif
    instruction_encode_loader_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * (DEPTH - 1));
    logic [1:0]  state;
    logic [31:0] fifo [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  occ;
    logic [31:0] addr;
    logic [15:0] cnt;
    logic [31:0] word;
    logic        legal;
    logic        accept;
    logic        push;
    logic        pop;
    assign word = bus.in_type == 3'd0 ? {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_shamt, bus.in_funct} :
                  bus.in_type == 3'd1 ? {6'h23, bus.in_rs, bus.in_rt, bus.in_imm} :
                  bus.in_type == 3'd2 ? {6'h2B, bus.in_rs, bus.in_rt, bus.in_imm} :
                  bus.in_type == 3'd3 ? {6'h04, bus.in_rs, bus.in_rt, bus.in_imm} :
                  bus.in_type == 3'd4 ? {6'h02, bus.in_target} : 32'h0000_0000;
`ifdef ENCODE_CHECK_EN
    assign legal = bus.in_type <= 3'd4;
`else
    assign legal = 1'b1;
`endif
    // Full FIFO blocks input even when a pop happens this cycle: in_ready is not a function of imem_ready.
    assign bus.in_ready   = state == LOAD && occ != 2'd2;
    assign accept         = bus.in_valid && bus.in_ready;
    assign push           = accept && legal;
    assign bus.imem_we    = (state == LOAD || state == DRAIN) && occ != 2'd0;
    assign pop            = bus.imem_we && bus.imem_ready;
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = bus.imem_we ? fifo[rd_ptr] : 32'h0000_0000;
    assign bus.busy       = state != IDLE;
    assign bus.done       = state == DONE;
    assign bus.count      = cnt;
    always_ff @(posedge clk)
        if (push) fifo[wr_ptr] <= word;
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
            addr   <= BASE_ADDR;
            cnt    <= 16'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop) begin
                rd_ptr <= ~rd_ptr;
                addr   <= addr == LAST_ADDR ? BASE_ADDR : addr + 32'd4;
                cnt    <= cnt == 16'hFFFF ? cnt : cnt + 16'd1;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
            case (state)
                IDLE: if (bus.start) begin
                    state <= LOAD;
                    addr  <= BASE_ADDR;
                    cnt   <= 16'd0;
                end
                LOAD:    if (accept && bus.in_last) state <= DRAIN;
                DRAIN:   if (occ == 2'd0) state <= DONE;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ENCODE_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) err <= 1'b0;
        else if (state == IDLE && bus.start) err <= 1'b0;
        else if (accept && !legal) err <= 1'b1;
    end
`endif
endmodule

// File: tb/tb_instruction_encode_loader.sv
// tb_instruction_encode_loader: randomized sessions scored against a queue-based reference model.
module tb_instruction_encode_loader;
    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int DEPTH = 4;
    typedef struct packed {
        logic [2:0]  ty;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tg;
        logic        last;
    } tuple_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic err;
    int total = 0;
    int bad = 0;
    int sess_n = 0;
    int wr_seen = 0;
    logic exp_err = 1'b0;
    logic [63:0] exp_q [$];
    logic [63:0] e;
    bit done_seen = 1'b0;
    bit accepted = 1'b0;
    bit rdy_rand = 1'b0;
    tuple_t cur;
    logic pw = 1'b0;
    logic [31:0] pa = 32'h0;
    logic [31:0] pd = 32'h0;

    instruction_encode_loader_if bus();
    instruction_encode_loader #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk),
        .reset(reset),
`ifdef ENCODE_CHECK_EN
        .err(err),
`endif
        .bus(bus)
    );
`ifndef ENCODE_CHECK_EN
    assign err = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] encode(input tuple_t t);
        case (t.ty)
            3'd0: return {6'h00, t.rs, t.rt, t.rd, t.sh, t.fn};
            3'd1: return {6'h23, t.rs, t.rt, t.imm};
            3'd2: return {6'h2B, t.rs, t.rt, t.imm};
            3'd3: return {6'h04, t.rs, t.rt, t.imm};
            3'd4: return {6'h02, t.tg};
            default: return 32'h0000_0000;
        endcase
    endfunction

    function automatic tuple_t rand_tuple(input logic last, input bit legal_only);
        tuple_t t;
        t.ty = (legal_only || $urandom_range(0, 9) != 0) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
        t.rs = 5'($urandom);
        t.rt = 5'($urandom);
        t.rd = 5'($urandom);
        t.sh = 5'($urandom);
        t.fn = 6'($urandom);
        t.imm = 16'($urandom);
        t.tg = 26'($urandom);
        t.last = last;
        return t;
    endfunction

    task automatic drive(input tuple_t t);
        cur = t;
        bus.in_type = t.ty;
        bus.in_rs = t.rs;
        bus.in_rt = t.rt;
        bus.in_rd = t.rd;
        bus.in_shamt = t.sh;
        bus.in_funct = t.fn;
        bus.in_imm = t.imm;
        bus.in_target = t.tg;
        bus.in_last = t.last;
    endtask

    // Reference: each accepted legal tuple becomes the next word of the session, at a wrapping address.
    task automatic model_accept(input tuple_t t);
`ifdef ENCODE_CHECK_EN
        if (t.ty > 3'd4) begin
            exp_err = 1'b1;
            return;
        end
`endif
        exp_q.push_back({BASE + 32'(4 * (sess_n % DEPTH)), encode(t)});
        sess_n++;
    endtask

    task automatic step();
        @(negedge clk);
        done_seen = bus.done;
        accepted = bus.in_valid && bus.in_ready;
        if (accepted && !reset) model_accept(cur);
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_we"}, 32'(bus.imem_we), 32'd0);
        chk({tag, "_addr"}, bus.imem_addr, BASE);
        chk({tag, "_wdata"}, bus.imem_wdata, 32'd0);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic open_session();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        sess_n = 0;
        exp_err = 1'b0;
        chk("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic send_one(input tuple_t t);
        int g = 0;
        drive(t);
        bus.in_valid = 1'b1;
        accepted = 1'b0;
        while (!accepted && g < 100) begin
            step();
            g++;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            total++;
            bad++;
            $display("FAIL send_timeout: tuple not accepted within %0d cycles", g);
        end
    endtask

    task automatic send_random(input int n);
        int sent = 0;
        int g = 0;
        drive(rand_tuple(n == 1, 1'b0));
        bus.in_valid = $urandom_range(0, 3) != 0;
        while (sent < n && g < 2000) begin
            bus.start = $urandom_range(0, 15) == 0;
            step();
            g++;
            if (accepted) begin
                sent++;
                drive(rand_tuple(sent == n - 1, 1'b0));
            end
            bus.in_valid = sent < n && $urandom_range(0, 3) != 0;
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        if (sent < n) begin
            total++;
            bad++;
            $display("FAIL send_random_timeout: sent %0d of %0d", sent, n);
        end
    endtask

    task automatic finish_session(input string tag);
        int g = 0;
        bus.in_valid = 1'b0;
        done_seen = 1'b0;
        while (!done_seen && g < 300) begin
            step();
            g++;
        end
        if (!done_seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: no done pulse after %0d cycles", tag, g);
        end else begin
            chk({tag, "_count"}, 32'(bus.count), 32'(sess_n > 65535 ? 65535 : sess_n));
            chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
            chk({tag, "_done_once"}, 32'(bus.done), 32'd0);
            chk({tag, "_busy_idle"}, 32'(bus.busy), 32'd0);
            chk({tag, "_ready_idle"}, 32'(bus.in_ready), 32'd0);
            chk({tag, "_err"}, 32'(err), 32'(exp_err));
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rdy_rand) bus.imem_ready = $urandom_range(0, 3) != 0;
    end

    // Monitor: every completed write must be the oldest expected word; stalled outputs must hold.
    always @(negedge clk) begin
        if (!reset && pw) begin
            chk("hold_we", 32'(bus.imem_we), 32'd1);
            chk("hold_addr", bus.imem_addr, pa);
            chk("hold_wdata", bus.imem_wdata, pd);
        end
        pw = !reset && bus.imem_we && !bus.imem_ready;
        pa = bus.imem_addr;
        pd = bus.imem_wdata;
        if (!reset && bus.imem_we && bus.imem_ready) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %h data %h with nothing expected", bus.imem_addr, bus.imem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", bus.imem_addr, e[63:32]);
                chk("wr_data", bus.imem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        tuple_t t;
        tuple_t tv [3];
        int idx;
        int w0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.imem_ready = 1'b1;
        drive(rand_tuple(1'b0, 1'b1));
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        reset = 1'b0;
        step();
        chk("idle_ready", 32'(bus.in_ready), 32'd0);

        // Single LW word.
        open_session();
        t = rand_tuple(1'b1, 1'b1);
        t.ty = 3'd1; t.rs = 5'd2; t.rt = 5'd3; t.imm = 16'h0010;
        send_one(t);
        chk("lw_we", 32'(bus.imem_we), 32'd1);
        chk("lw_addr", bus.imem_addr, BASE);
        chk("lw_wdata", bus.imem_wdata, 32'h8C43_0010);
        finish_session("lw");

        // R-type then J.
        open_session();
        t = rand_tuple(1'b0, 1'b1);
        t.ty = 3'd0; t.rs = 5'd1; t.rt = 5'd2; t.rd = 5'd3; t.sh = 5'd0; t.fn = 6'h20;
        bus.imem_ready = 1'b0;
        send_one(t);
        chk("r_wdata", bus.imem_wdata, 32'h0022_1820);
        bus.imem_ready = 1'b1;
        t = rand_tuple(1'b1, 1'b1);
        t.ty = 3'd4; t.tg = 26'h000_0040;
        send_one(t);
        finish_session("rj");

        // Stall: memory not ready for 5 cycles, only two tuples fit.
        open_session();
        for (int i = 0; i < 3; i++) tv[i] = rand_tuple(i == 2, 1'b1);
        bus.imem_ready = 1'b0;
        idx = 0;
        repeat (5) begin
            drive(tv[idx]);
            bus.in_valid = 1'b1;
            step();
            if (accepted) idx++;
        end
        chk("stall_accepted", 32'(idx), 32'd2);
        chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
        chk("stall_we", 32'(bus.imem_we), 32'd1);
        chk("stall_addr", bus.imem_addr, BASE);
        bus.imem_ready = 1'b1;
        step();
        chk("no_passthrough", 32'(accepted), 32'd0);
        if (accepted) idx++;
        if (idx < 3) send_one(tv[2]);
        finish_session("stall");

        // Reset after the first of three writes.
        open_session();
        for (int i = 0; i < 3; i++) tv[i] = rand_tuple(i == 2, 1'b1);
        bus.imem_ready = 1'b0;
        send_one(tv[0]);
        send_one(tv[1]);
        w0 = wr_seen;
        drive(tv[2]);
        bus.in_valid = 1'b1;
        bus.imem_ready = 1'b1;
        step();
        bus.imem_ready = 1'b0;
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        check_reset_vals("midreset");
        chk("midreset_writes", 32'(wr_seen), 32'(w0 + 1));
        reset = 1'b0;
        exp_q.delete();
        bus.imem_ready = 1'b1;
        w0 = wr_seen;
        repeat (5) step();
        chk("no_write_after_reset", 32'(wr_seen), 32'(w0));
        open_session();
        send_one(rand_tuple(1'b1, 1'b1));
        finish_session("post_reset");

        // Six words through a four-word window.
        open_session();
        send_random(6);
        finish_session("wrap");

`ifdef ENCODE_CHECK_EN
        open_session();
        t = rand_tuple(1'b1, 1'b1);
        t.ty = 3'd6;
        send_one(t);
        finish_session("illegal");
        chk("illegal_err_sticky", 32'(err), 32'd1);
`endif

        rdy_rand = 1'b1;
        for (int s = 0; s < 30; s++) begin
            open_session();
            send_random($urandom_range(1, 10));
            finish_session("rand");
        end
        rdy_rand = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
